// File: rtl/alarm_scheduler_if.sv
// Alarm scheduler bus: running time in, slot programming and user controls in,
// ring/snooze status out.
interface alarm_scheduler_if #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
);
  logic [1:0]           cur_h1;
  logic [3:0]           cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;
  logic                 wr_en;
  logic [SLOT_W-1:0]    wr_slot;
  logic [1:0]           wr_h1;
  logic [3:0]           wr_h0, wr_m1, wr_m0;
  logic                 wr_arm;
  logic                 snooze_req, stop_req;
  logic                 alarm;
  logic [SLOT_W-1:0]    active_slot;
  logic                 snoozing;
  logic [NUM_SLOTS-1:0] armed_mask;
  logic                 wr_err;

  modport master (
    output cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0,
    output wr_en, wr_slot, wr_h1, wr_h0, wr_m1, wr_m0, wr_arm,
    output snooze_req, stop_req,
    input  alarm, active_slot, snoozing, armed_mask, wr_err
  );

  modport slave (
    input  cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0,
    input  wr_en, wr_slot, wr_h1, wr_h0, wr_m1, wr_m0, wr_arm,
    input  snooze_req, stop_req,
    output alarm, active_slot, snoozing, armed_mask, wr_err
  );
endinterface

// File: rtl/alarm_scheduler.sv
// Multi-slot BCD alarm: per-slot time compare, lowest-index arbitration,
// and a ring / snooze / auto-timeout sequencer.
module alarm_slot (
  input  logic        clk_1s,
  input  logic        reset,
  input  logic        we_i,
  input  logic        arm_i,
  input  logic [13:0] time_i,
  input  logic [13:0] cur_i,
  input  logic        on_min_i,
  output logic        armed_o,
  output logic        match_o
);
  logic [13:0] time_q;
  logic        armed_q;

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      time_q  <= '0;
      armed_q <= 1'b0;
    end else if (we_i) begin
      time_q  <= time_i;
      armed_q <= arm_i;
    end
  end

  assign armed_o = armed_q;
  assign match_o = armed_q && on_min_i && (cur_i == time_q);
endmodule

module alarm_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_W     = 2,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60
) (
  input logic               clk_1s,
  input logic               reset,
  alarm_scheduler_if.slave  bus
);
  localparam int MAX_SEC = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
  localparam int CNT_W   = $clog2(MAX_SEC + 1);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNZ_INIT  = CNT_W'(SNOOZE_SEC - 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   ring_cnt_q, ring_cnt_d, snz_cnt_q, snz_cnt_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               alarm_q, snz_q, wr_err_q;
  logic [13:0]        wr_time, cur_time;
  logic               time_ok, slot_ok, wr_ok, on_min, cancel;
  logic [NUM_SLOTS-1:0] match, armed, slot_we;
  logic               win_vld;
  logic [SLOT_W-1:0]  win_idx;

  assign wr_time  = {bus.wr_h1, bus.wr_h0, bus.wr_m1, bus.wr_m0};
  assign cur_time = {bus.cur_h1, bus.cur_h0, bus.cur_m1, bus.cur_m0};
  assign on_min   = (bus.cur_s1 == 4'd0) && (bus.cur_s0 == 4'd0);
  assign time_ok  = ((bus.wr_h1 < 2'd2 && bus.wr_h0 <= 4'd9) ||
                     (bus.wr_h1 == 2'd2 && bus.wr_h0 <= 4'd3)) &&
                    (bus.wr_m1 <= 4'd5) && (bus.wr_m0 <= 4'd9);
  assign slot_ok  = 32'(bus.wr_slot) < 32'(NUM_SLOTS);
  assign wr_ok    = bus.wr_en && time_ok && slot_ok;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign slot_we[i] = wr_ok && (bus.wr_slot == SLOT_W'(i));
    alarm_slot u_slot (
      .clk_1s   (clk_1s),
      .reset    (reset),
      .we_i     (slot_we[i]),
      .arm_i    (bus.wr_arm),
      .time_i   (wr_time),
      .cur_i    (cur_time),
      .on_min_i (on_min),
      .armed_o  (armed[i]),
      .match_o  (match[i])
    );
  end

  // Lowest index wins; scanning downward leaves it as the last assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (match[i]) begin
        win_vld = 1'b1;
        win_idx = SLOT_W'(i);
      end
    end
  end

  // Disarming the slot that is ringing/snoozing silences it outright.
  assign cancel = wr_ok && !bus.wr_arm && (bus.wr_slot == slot_q) && (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    slot_d     = slot_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d    = RING;
          ring_cnt_d = '0;
          slot_d     = win_idx;
        end
      end
      RING: begin
        ring_cnt_d = ring_cnt_q + CNT_W'(1);
        if (bus.stop_req) begin
          state_d = IDLE;
        end else if (bus.snooze_req) begin
          state_d   = SNOOZE;
          snz_cnt_d = SNZ_INIT;
        end else if (ring_cnt_q == RING_LAST) begin
          state_d = IDLE;
        end
      end
      SNOOZE: begin
        if (bus.stop_req) begin
          state_d = IDLE;
        end else if (snz_cnt_q == '0) begin
          state_d    = RING;
          ring_cnt_d = '0;
        end else begin
          snz_cnt_d = snz_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (cancel) state_d = IDLE;
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      slot_q     <= '0;
      alarm_q    <= 1'b0;
      snz_q      <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      slot_q     <= slot_d;
      alarm_q    <= (state_d == RING);
      snz_q      <= (state_d == SNOOZE);
      wr_err_q   <= bus.wr_en && !wr_ok;
    end
  end

  assign bus.alarm       = alarm_q;
  assign bus.snoozing    = snz_q;
  assign bus.active_slot = slot_q;
  assign bus.armed_mask  = armed;
  assign bus.wr_err      = wr_err_q;
endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with a seconds-of-day reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_alarm_scheduler;
  localparam int NS  = 4;
  localparam int SW  = 3;
  localparam int SNZ = 5;
  localparam int RS  = 60;

  logic clk_1s = 1'b0;
  logic reset  = 1'b1;

  alarm_scheduler_if #(.NUM_SLOTS(NS), .SLOT_W(SW)) bus ();

  alarm_scheduler #(.NUM_SLOTS(NS), .SLOT_W(SW), .SNOOZE_SEC(SNZ), .RING_SEC(RS)) dut (
    .clk_1s (clk_1s),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_1s = ~clk_1s;

  int n_chk  = 0;
  int n_fail = 0;
  int now    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_time(input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    bus.cur_h1 = 2'(h / 10); bus.cur_h0 = 4'(h % 10);
    bus.cur_m1 = 4'(m / 10); bus.cur_m0 = 4'(m % 10);
    bus.cur_s1 = 4'(s / 10); bus.cur_s0 = 4'(s % 10);
  endtask

  // One clock edge; the running time advances like the timekeeping block.
  task automatic tk();
    @(posedge clk_1s);
    #1;
    now = (now + 1) % 86400;
    set_time(now);
  endtask

  task automatic jump(input int hh, input int mm, input int ss);
    now = hh * 3600 + mm * 60 + ss;
    set_time(now);
  endtask

  task automatic wr(input int slot, input int hh, input int mm, input bit arm);
    bus.wr_en   = 1'b1;
    bus.wr_slot = SW'(slot);
    bus.wr_h1   = 2'(hh / 10); bus.wr_h0 = 4'(hh % 10);
    bus.wr_m1   = 4'(mm / 10); bus.wr_m0 = 4'(mm % 10);
    bus.wr_arm  = arm;
    tk();
    bus.wr_en   = 1'b0;
  endtask

  // Reference model: slots as minute-of-day, ring/snooze as seconds remaining.
  int m_min [NS];
  bit m_arm [NS];
  int mode, ring_left, snz_left, m_act;
  bit m_err;

  initial begin : scoreboard
    int c_now, c_slot, c_h1, c_h0, c_m1, c_m0, win, prev, mk;
    bit c_rst, c_en, c_arm, c_snz, c_stop, ok;
    mode = 0; ring_left = 0; snz_left = 0; m_act = 0; m_err = 0;
    forever begin
      @(posedge clk_1s);
      c_rst = reset; c_now = now; c_en = bus.wr_en; c_arm = bus.wr_arm;
      c_slot = int'(bus.wr_slot); c_h1 = int'(bus.wr_h1); c_h0 = int'(bus.wr_h0);
      c_m1 = int'(bus.wr_m1); c_m0 = int'(bus.wr_m0);
      c_snz = bus.snooze_req; c_stop = bus.stop_req;
      @(negedge clk_1s);
      if (c_rst || reset) begin
        mode = 0; m_act = 0; m_err = 0;
        for (int i = 0; i < NS; i++) begin m_min[i] = 0; m_arm[i] = 0; end
      end else begin
        ok = c_en && c_slot < NS && c_h1 <= 2 && c_h0 <= 9 &&
             (c_h1 * 10 + c_h0) < 24 && c_m1 <= 5 && c_m0 <= 9;
        m_err = c_en && !ok;
        win = -1;
        if (c_now % 60 == 0)
          for (int i = NS - 1; i >= 0; i--)
            if (m_arm[i] && m_min[i] * 60 == c_now) win = i;
        prev = mode;
        case (mode)
          0: if (win >= 0) begin mode = 1; ring_left = RS - 1; m_act = win; end
          1: if (c_stop) mode = 0;
             else if (c_snz) begin mode = 2; snz_left = SNZ; end
             else if (ring_left == 0) mode = 0;
             else ring_left--;
          default: if (c_stop) mode = 0;
             else begin
               snz_left--;
               if (snz_left == 0) begin mode = 1; ring_left = RS - 1; end
             end
        endcase
        if (ok && prev != 0 && c_slot == m_act && !c_arm) mode = 0;
        if (ok) begin
          m_min[c_slot] = (c_h1 * 10 + c_h0) * 60 + c_m1 * 10 + c_m0;
          m_arm[c_slot] = c_arm;
        end
      end
      mk = 0;
      for (int i = 0; i < NS; i++) if (m_arm[i]) mk |= (1 << i);
      chk("sb_alarm",    int'(bus.alarm),       int'(mode == 1));
      chk("sb_snoozing", int'(bus.snoozing),    int'(mode == 2));
      chk("sb_active",   int'(bus.active_slot), m_act);
      chk("sb_armed",    int'(bus.armed_mask),  mk);
      chk("sb_wr_err",   int'(bus.wr_err),      int'(m_err));
    end
  end

  initial begin
    bus.wr_en = 0; bus.wr_slot = '0; bus.wr_h1 = '0; bus.wr_h0 = '0;
    bus.wr_m1 = '0; bus.wr_m0 = '0; bus.wr_arm = 0;
    bus.snooze_req = 0; bus.stop_req = 0;
    set_time(0);
    @(posedge clk_1s); #1;
    chk("rst_alarm", int'(bus.alarm), 0);
    chk("rst_snoozing", int'(bus.snoozing), 0);
    chk("rst_armed", int'(bus.armed_mask), 0);
    chk("rst_active", int'(bus.active_slot), 0);
    chk("rst_wr_err", int'(bus.wr_err), 0);
    reset = 0;

    // slot1 07:30: rings on the :00 edge, times out after exactly RS edges
    jump(7, 29, 58);
    wr(1, 7, 30, 1);
    chk("t1_armed", int'(bus.armed_mask), 2);
    tk(); tk();
    chk("t1_alarm_on", int'(bus.alarm), 1);
    chk("t1_active", int'(bus.active_slot), 1);
    repeat (RS - 1) tk();
    chk("t1_alarm_last", int'(bus.alarm), 1);
    tk();
    chk("t1_alarm_off", int'(bus.alarm), 0);

    // slots 0 and 2 tie at 06:00: slot 0 wins, slot 2 is dropped
    jump(5, 59, 57);
    wr(0, 6, 0, 1);
    wr(2, 6, 0, 1);
    tk(); tk();
    chk("t2_alarm", int'(bus.alarm), 1);
    chk("t2_active", int'(bus.active_slot), 0);
    chk("t2_armed", int'(bus.armed_mask), 7);
    bus.stop_req = 1; tk(); bus.stop_req = 0;
    chk("t2_stop", int'(bus.alarm), 0);
    repeat (3) tk();
    chk("t2_no_slot2", int'(bus.alarm), 0);
    chk("t2_hold_active", int'(bus.active_slot), 0);

    // snooze for SNZ edges then ring again, then stop
    jump(5, 59, 59);
    tk(); tk();
    bus.snooze_req = 1; tk(); bus.snooze_req = 0;
    chk("t3_snz_alarm", int'(bus.alarm), 0);
    chk("t3_snz_flag", int'(bus.snoozing), 1);
    repeat (SNZ - 1) tk();
    chk("t3_still_snz", int'(bus.snoozing), 1);
    tk();
    chk("t3_rering", int'(bus.alarm), 1);
    chk("t3_rering_snz", int'(bus.snoozing), 0);
    bus.stop_req = 1; tk(); bus.stop_req = 0;
    chk("t3_stop", int'(bus.alarm), 0);

    // stop beats snooze on the same edge
    jump(5, 59, 59);
    tk(); tk();
    bus.snooze_req = 1; bus.stop_req = 1; tk();
    bus.snooze_req = 0; bus.stop_req = 0;
    chk("t4_alarm", int'(bus.alarm), 0);
    chk("t4_snoozing", int'(bus.snoozing), 0);

    // rejected writes leave the slots alone; 23:59 is the last valid time
    wr(0, 24, 0, 0);
    chk("t5_err_24", int'(bus.wr_err), 1);
    chk("t5_mask_24", int'(bus.armed_mask), 7);
    tk();
    chk("t5_err_pulse", int'(bus.wr_err), 0);
    wr(1, 12, 60, 0);
    chk("t5_err_m60", int'(bus.wr_err), 1);
    chk("t5_mask_m60", int'(bus.armed_mask), 7);
    wr(4, 12, 0, 0);
    chk("t5_err_slot4", int'(bus.wr_err), 1);
    chk("t5_mask_slot4", int'(bus.armed_mask), 7);
    wr(3, 23, 59, 0);
    chk("t5_ok_2359", int'(bus.wr_err), 0);

    // disarming the ringing slot silences it on the same edge
    wr(3, 8, 0, 1);
    jump(7, 59, 59);
    tk(); tk();
    chk("t6_ring3", int'(bus.alarm), 1);
    chk("t6_active3", int'(bus.active_slot), 3);
    wr(3, 8, 0, 0);
    chk("t6_cancel", int'(bus.alarm), 0);
    chk("t6_mask", int'(bus.armed_mask), 7);

    // async reset mid-snooze
    jump(5, 59, 59);
    tk(); tk();
    bus.snooze_req = 1; tk(); bus.snooze_req = 0;
    tk();
    chk("t7_in_snz", int'(bus.snoozing), 1);
    #2 reset = 1;
    #1;
    chk("t7_rst_alarm", int'(bus.alarm), 0);
    chk("t7_rst_snz", int'(bus.snoozing), 0);
    chk("t7_rst_mask", int'(bus.armed_mask), 0);
    tk(); reset = 0;

    // async reset mid-ring drops alarm before the next edge
    jump(5, 59, 58);
    wr(0, 6, 0, 1);
    tk(); tk();
    chk("t8_ring", int'(bus.alarm), 1);
    #2 reset = 1;
    #1;
    chk("t8_rst_alarm", int'(bus.alarm), 0);
    tk(); reset = 0;
    tk();
    chk("t8_idle", int'(bus.alarm), 0);

    repeat (2) tk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
